// File: rtl/key_debounce.sv
// key_debounce: synchronizes, debounces and classifies one raw push-button
// input. Produces a clean pressed level plus one-cycle press, release,
// short-press and long-press strobes, all registered.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | key released and stable
// DEB_PRESS   | press seen, counting stable pressed samples
// PRESSED     | press accepted, hold time running
// DEB_RELEASE | release seen, counting stable released samples; hold runs on
module key_debounce #(
    parameter int DEB_CYCLES  = 10,
    parameter int LONG_CYCLES = 50,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic          PIN_IDLE  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    logic          sync_q1, sync_q2;
    logic          act;
    state_t        state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_done_q, long_done_d;
    logic          level_d, press_d, release_d, short_d, long_d;
    logic          holding, long_hit;

    // Two-flop synchronizer; resets to the idle pin level so no phantom press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= PIN_IDLE;
            sync_q2 <= PIN_IDLE;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    // 1 = pressed, independent of pin polarity.
    assign act = sync_q2 ^ PIN_IDLE;

    // Next-state, counters and strobe decisions.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = key_level;
        press_d     = 1'b0;
        release_d   = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;

        holding  = (state_q == PRESSED) || (state_q == DEB_RELEASE);
        long_hit = holding && (hold_cnt_q == HOLD_LAST) && !long_done_q;

        // Hold time keeps running through release bounces.
        if (holding) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
            if (long_hit) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (act) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = DEB_ONE;
                end
            end
            DEB_PRESS: begin
                if (!act) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    deb_cnt_d   = '0;
                    level_d     = 1'b1;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            PRESSED: begin
                if (!act) begin
                    state_d   = DEB_RELEASE;
                    deb_cnt_d = DEB_ONE;
                end
            end
            DEB_RELEASE: begin
                if (act) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    // A long press reaching its mark on this same edge wins.
                    short_d   = !long_done_q && !long_hit;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_done_q   <= long_done_d;
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
        end
    end

endmodule
